// File: rtl/ber_sim_pkg.sv
// Shared constants and helpers for the BER simulation datapath blocks.
package ber_sim_pkg;

  localparam int SHIFT_W = 3;

  // Clamp a signed intermediate into the unsigned range [0, hi].
  function automatic logic [31:0] clamp_value(input logic signed [31:0] y,
                                              input logic signed [31:0] hi);
    logic [31:0] r;
    if (y < 0)
      r = '0;
    else if (y > hi)
      r = hi;
    else
      r = y;
    return r;
  endfunction

endpackage

// File: rtl/noise_fifo_sync.sv
// Single-clock FIFO for noise words; the read port shows the head word combinationally.
module noise_fifo_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/noise_adder_mc.sv
// Multi-lane noise adder: buffered signed noise is shifted, added to offset-binary samples and clamped.
// Optional saturation counter port compiled in with NOISE_ADDER_SAT_COUNT_EN.
module noise_adder_mc
  import ber_sim_pkg::*;
#(
  parameter int LANES             = 2,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int NOISE_RESOLUTION  = 8,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                en,
  input  logic [LANES*NOISE_RESOLUTION-1:0]   noise_in,
  input  logic                                noise_in_valid,
  output logic                                noise_in_ready,
  input  logic [LANES*SIGNAL_RESOLUTION-1:0]  signal_in,
  input  logic                                signal_in_valid,
  input  logic [SHIFT_W-1:0]                  noise_shift,
  output logic [LANES*SIGNAL_RESOLUTION-1:0]  signal_out,
  output logic                                valid,
  output logic [31:0]                         starve_count
`ifdef NOISE_ADDER_SAT_COUNT_EN
  ,
  output logic [31:0]                         sat_count
`endif
);

  localparam int NR      = NOISE_RESOLUTION;
  localparam int SR      = SIGNAL_RESOLUTION;
  localparam int NW      = LANES * NR;
  localparam int SW      = LANES * SR;
  localparam int SIG_MAX = (1 << SR) - 1;

  logic              consume;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [NW-1:0]     fifo_rdata;
  logic [NW-1:0]     noise_word;
  logic [SHIFT_W-1:0] shift_eff;
  logic [SW-1:0]     result_next;
  logic [SW-1:0]     signal_out_reg;
  logic              valid_reg;
  logic [31:0]       starve_count_reg;

  assign noise_in_ready = rstn & ~fifo_full;
  assign push           = noise_in_valid & noise_in_ready;
  assign consume        = en & signal_in_valid;
  assign pop            = consume & ~fifo_empty;
  // A starved beat sees all-zero noise.
  assign noise_word     = fifo_empty ? '0 : fifo_rdata;
  assign shift_eff      = (int'(noise_shift) >= NR) ? SHIFT_W'(NR - 1) : noise_shift;

  noise_fifo_sync #(
    .WIDTH(NW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .wdata(noise_in),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef NOISE_ADDER_SAT_COUNT_EN
  logic [LANES-1:0] sat_lanes;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [NR-1:0] n_lane;
      logic signed [31:0]   y_lane;
      assign n_lane = $signed(noise_word[gi*NR +: NR]) >>> shift_eff;
      assign y_lane = $signed(32'(signal_in[gi*SR +: SR])) + 32'(n_lane);
      assign result_next[gi*SR +: SR] = SR'(clamp_value(y_lane, SIG_MAX));
`ifdef NOISE_ADDER_SAT_COUNT_EN
      assign sat_lanes[gi] = (y_lane < 0) || (y_lane > SIG_MAX);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_reg        <= 1'b0;
      signal_out_reg   <= '0;
      starve_count_reg <= '0;
    end else begin
      valid_reg <= consume;
      if (consume) begin
        signal_out_reg <= result_next;
        if (fifo_empty && (starve_count_reg != '1))
          starve_count_reg <= starve_count_reg + 32'd1;
      end
    end
  end

  assign signal_out   = signal_out_reg;
  assign valid        = valid_reg;
  assign starve_count = starve_count_reg;

`ifdef NOISE_ADDER_SAT_COUNT_EN
  logic [31:0] sat_count_reg;
  logic [32:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_count_reg};
    for (int i = 0; i < LANES; i++)
      sat_sum = sat_sum + 33'(sat_lanes[i]);
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      sat_count_reg <= '0;
    else if (consume)
      sat_count_reg <= sat_sum[32] ? '1 : sat_sum[31:0];
  end

  assign sat_count = sat_count_reg;
`endif

endmodule

// File: tb/tb_noise_adder_mc.sv
// Directed self-checking bench for noise_adder_mc (2 lanes, 8-bit samples and noise, depth 4).
module tb_noise_adder_mc;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [15:0] noise_in;
  logic        noise_in_valid;
  logic        noise_in_ready;
  logic [15:0] signal_in;
  logic        signal_in_valid;
  logic [2:0]  noise_shift;
  logic [15:0] signal_out;
  logic        valid;
  logic [31:0] starve_count;
`ifdef NOISE_ADDER_SAT_COUNT_EN
  logic [31:0] sat_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  noise_adder_mc #(
    .LANES(2),
    .SIGNAL_RESOLUTION(8),
    .NOISE_RESOLUTION(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .noise_in       (noise_in),
    .noise_in_valid (noise_in_valid),
    .noise_in_ready (noise_in_ready),
    .signal_in      (signal_in),
    .signal_in_valid(signal_in_valid),
    .noise_shift    (noise_shift),
    .signal_out     (signal_out),
    .valid          (valid),
    .starve_count   (starve_count)
`ifdef NOISE_ADDER_SAT_COUNT_EN
    ,
    .sat_count      (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    $display("[%0t] check %s observed=%0h expected=%0h", $time, tag, got, exp);
  endtask

  task automatic push_word(input logic [15:0] w);
    noise_in       = w;
    noise_in_valid = 1'b1;
    tick();
    noise_in_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; noise_in = '0; noise_in_valid = 1'b0;
    signal_in = '0; signal_in_valid = 1'b0; noise_shift = '0;
    tick(); tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_out", 32'(signal_out), 32'd0);
    check("rst_starve", starve_count, 32'd0);
    check("rst_ready", 32'(noise_in_ready), 32'd0);
`ifdef NOISE_ADDER_SAT_COUNT_EN
    check("rst_sat", sat_count, 32'd0);
`endif
    rstn = 1'b1;
    tick();
    check("ready_after_rst", 32'(noise_in_ready), 32'd1);
    check("idle_valid", 32'(valid), 32'd0);

    // Basic add: noise {-5,+3}, samples {100,200}
    push_word(16'h03FB);
    signal_in = 16'hC864; signal_in_valid = 1'b1; en = 1'b1;
    tick();
    signal_in_valid = 1'b0;
    check("add_valid", 32'(valid), 32'd1);
    check("add_out", 32'(signal_out), 32'h0000CB5F);
    tick();
    check("idle_valid_low", 32'(valid), 32'd0);
    check("idle_out_hold", 32'(signal_out), 32'h0000CB5F);

    // Clamping: noise {-128,+127}, samples {10,250}
    push_word(16'h7F80);
    signal_in = 16'hFA0A; signal_in_valid = 1'b1;
    tick();
    signal_in_valid = 1'b0;
    check("clamp_out", 32'(signal_out), 32'h0000FF00);
`ifdef NOISE_ADDER_SAT_COUNT_EN
    check("clamp_sat", sat_count, 32'd2);
`endif
    tick();

    // Back-pressure: fill depth 4, fifth push dropped
    push_word(16'h0101);
    push_word(16'h0202);
    push_word(16'h0303);
    push_word(16'h0404);
    check("full_ready", 32'(noise_in_ready), 32'd0);
    push_word(16'h7F7F);
    check("full_ready_hold", 32'(noise_in_ready), 32'd0);
    en = 1'b0; signal_in = 16'h6464; signal_in_valid = 1'b1;
    tick();
    check("en0_valid", 32'(valid), 32'd0);
    check("en0_ready", 32'(noise_in_ready), 32'd0);
    en = 1'b1;
    tick();
    check("drain0_out", 32'(signal_out), 32'h00006565);
    check("drain0_ready", 32'(noise_in_ready), 32'd1);
    tick();
    check("drain1_out", 32'(signal_out), 32'h00006666);
    tick();
    check("drain2_out", 32'(signal_out), 32'h00006767);
    tick();
    check("drain3_out", 32'(signal_out), 32'h00006868);
    check("drain_starve", starve_count, 32'd0);
    signal_in_valid = 1'b0;
    tick();

    // Starvation: three beats {50,60} with an empty buffer
    signal_in = 16'h3C32; signal_in_valid = 1'b1;
    tick();
    check("starve0_out", 32'(signal_out), 32'h00003C32);
    tick();
    check("starve1_out", 32'(signal_out), 32'h00003C32);
    tick();
    check("starve2_out", 32'(signal_out), 32'h00003C32);
    check("starve_count", starve_count, 32'd3);
    signal_in_valid = 1'b0;
    tick();

    // Shift: noise {-8,+8} >>> 2, then {-128,-128} >>> 7
    push_word(16'h08F8);
    noise_shift = 3'd2; signal_in = 16'h6464; signal_in_valid = 1'b1;
    tick();
    signal_in_valid = 1'b0;
    check("shift2_out", 32'(signal_out), 32'h00006662);
    push_word(16'h8080);
    noise_shift = 3'd7; signal_in_valid = 1'b1;
    tick();
    signal_in_valid = 1'b0;
    check("shift7_out", 32'(signal_out), 32'h00006363);
    check("shift_starve", starve_count, 32'd3);
    noise_shift = 3'd0;

    // No bypass: push into an empty buffer alongside a beat
    noise_in = 16'h0505; noise_in_valid = 1'b1; signal_in_valid = 1'b1;
    tick();
    check("nobypass_out", 32'(signal_out), 32'h00006464);
    check("nobypass_starve", starve_count, 32'd4);
    noise_in = 16'h0606;
    tick();
    noise_in_valid = 1'b0;
    check("pushpop_out", 32'(signal_out), 32'h00006969);
    check("pushpop_starve", starve_count, 32'd4);
    tick();
    signal_in_valid = 1'b0;
    check("pushpop_next_out", 32'(signal_out), 32'h00006A6A);
    tick();

    // Reset mid-stream with two words buffered and a beat in flight
    push_word(16'h1010);
    push_word(16'h2020);
    signal_in_valid = 1'b1;
    tick();
    check("pre_rst_out", 32'(signal_out), 32'h00007474);
    rstn = 1'b0;
    tick();
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_out", 32'(signal_out), 32'd0);
    check("midrst_starve", starve_count, 32'd0);
    check("midrst_ready", 32'(noise_in_ready), 32'd0);
`ifdef NOISE_ADDER_SAT_COUNT_EN
    check("midrst_sat", sat_count, 32'd0);
`endif
    rstn = 1'b1; signal_in_valid = 1'b0;
    tick();
    check("post_rst_ready", 32'(noise_in_ready), 32'd1);
    check("post_rst_valid", 32'(valid), 32'd0);
    signal_in_valid = 1'b1;
    tick();
    signal_in_valid = 1'b0;
    check("post_rst_out", 32'(signal_out), 32'h00006464);
    check("post_rst_starve", starve_count, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
